// File: rtl/servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// servo_pulse_decoder
//
// Measures the high time of one RC-servo PWM line and decodes it into an 8-bit
// position code (the inverse of the arm's PWM generators). One instance per
// channel.
//
// Ports:
//   CLOCK_50     in   system clock (50 MHz)
//   KEY0         in   asynchronous active-low reset
//   pwm_in       in   asynchronous servo PWM input
//   position     out  last decoded position code (0..255)
//   pulse_width  out  last accepted high time, in CLOCK_50 cycles
//   valid        out  one-cycle strobe: position/pulse_width updated
//   err_short    out  one-cycle strobe: pulse shorter than SHORT_LIMIT_CYC
//   err_long     out  one-cycle strobe: pulse reached LONG_LIMIT_CYC
//   signal_lost  out  level: no rising edge for TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module servo_pulse_decoder #(
  parameter int MIN_PULSE_CYC   = 50000,
  parameter int STEP_CYC        = 196,
  parameter int SHORT_LIMIT_CYC = 25000,
  parameter int LONG_LIMIT_CYC  = 125000,
  parameter int TIMEOUT_CYC     = 1500000,
  parameter int WIDTH_W         = 17
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic               pwm_in,
  output logic [7:0]         position,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic               valid,
  output logic               err_short,
  output logic               err_long,
  output logic               signal_lost
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [WIDTH_W-1:0] W_ONE   = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] SHORT_W = WIDTH_W'(SHORT_LIMIT_CYC);
  localparam logic [WIDTH_W-1:0] MIN_W   = WIDTH_W'(MIN_PULSE_CYC);
  localparam logic [WIDTH_W-1:0] LONG_W  = WIDTH_W'(LONG_LIMIT_CYC);
  localparam logic [WIDTH_W-1:0] LONG_M1 = WIDTH_W'(LONG_LIMIT_CYC - 1);
  localparam logic [WIDTH_W-1:0] STEP_M1 = WIDTH_W'(STEP_CYC - 1);
  localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]    TO_MAX  = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]    TO_M1   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, then one more stage (line) that the
  // FSM reads. The extra stage places every decision on the third edge after
  // the first edge that samples pwm_in low.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_ff;
  logic       line;
  logic [1:0] settle;   // counts edges since reset until line reflects pwm_in

  // NOTE: async active-low reset lives in the sensitivity list; every register
  // below is cleared the instant KEY0 falls, without waiting for a clock.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sync_ff <= '0;
      line    <= 1'b0;
      settle  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make the flops shift as a chain; blocking
      // ones would collapse the synchronizer into a single stage.
      sync_ff <= {sync_ff[0], pwm_in};
      line    <= sync_ff[1];
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  // Until the pipeline has refilled after reset, line reads 0 regardless of the
  // pin; WAIT_LOW must not treat that as the line being low, or a pulse already
  // in progress at reset release would be measured.
  logic pipe_ready;
  assign pipe_ready = (settle == 2'd3);

  // ---------------------------------------------------------------------------
  // FSM + datapath
  // ---------------------------------------------------------------------------
  state_t             state, state_n;
  logic [WIDTH_W-1:0] width, width_n;       // high cycles of current pulse
  logic [WIDTH_W-1:0] pre, pre_n;           // step prescaler: excess mod STEP_CYC
  logic [7:0]         pos, pos_n;           // running position of current pulse
  logic [TO_W-1:0]    to_cnt, to_n;         // armed cycles since last accept
  logic [7:0]         position_n;
  logic [WIDTH_W-1:0] pulse_width_n;
  logic               valid_n, err_short_n, err_long_n, lost_n;

  always_comb begin
    // NOTE: every variable gets a default before the case statement so no path
    // leaves one unassigned; that is what keeps this block free of latches.
    state_n       = state;
    width_n       = width;
    pre_n         = pre;
    pos_n         = pos;
    to_n          = to_cnt;
    position_n    = position;
    pulse_width_n = pulse_width;
    valid_n       = 1'b0;
    err_short_n   = 1'b0;
    err_long_n    = 1'b0;
    lost_n        = signal_lost;

    unique case (state)
      WAIT_LOW: begin
        if (pipe_ready && !line) state_n = ARMED;
      end

      ARMED: begin
        // In ARMED the line was low last cycle, so a high line is a rising edge.
        // It is checked first so it wins over a coincident timeout.
        if (line) begin
          state_n = HIGH;
          width_n = W_ONE;
          pre_n   = '0;
          pos_n   = 8'd0;
        end else if (to_cnt != TO_MAX) begin
          to_n = to_cnt + TO_ONE;
          if (to_cnt == TO_M1) lost_n = 1'b1;
        end
      end

      HIGH: begin
        if (line) begin
          if (width == LONG_M1) begin
            width_n    = LONG_W;
            err_long_n = 1'b1;
            state_n    = WAIT_LOW;
          end else begin
            width_n = width + W_ONE;
            // The new width exceeds MIN_PULSE_CYC: one more cycle of excess.
            // Every STEP_CYC cycles of excess advance the position by one,
            // which equals floor(excess / STEP_CYC) without a divider.
            if (width >= MIN_W) begin
              if (pre == STEP_M1) begin
                pre_n = '0;
                if (pos != 8'hFF) pos_n = pos + 8'd1;
              end else begin
                pre_n = pre + W_ONE;
              end
            end
          end
        end else if (width < SHORT_W) begin
          err_short_n = 1'b1;
          state_n     = ARMED;
        end else begin
          valid_n       = 1'b1;
          pulse_width_n = width;
          position_n    = pos;
          lost_n        = 1'b0;
          to_n          = '0;
          state_n       = ARMED;
        end
      end

      default: state_n = WAIT_LOW;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state       <= WAIT_LOW;
      width       <= '0;
      pre         <= '0;
      pos         <= 8'd0;
      to_cnt      <= '0;
      position    <= 8'd0;
      pulse_width <= '0;
      valid       <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_n;
      width       <= width_n;
      pre         <= pre_n;
      pos         <= pos_n;
      to_cnt      <= to_n;
      position    <= position_n;
      pulse_width <= pulse_width_n;
      valid       <= valid_n;
      err_short   <= err_short_n;
      err_long    <= err_long_n;
      signal_lost <= lost_n;
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_servo_pulse_decoder
//
// Drives the decoder with directed and random pulse trains using scaled-down
// timing parameters. A pulse-level reference model predicts, for each pulse,
// which strobe fires on which clock edge and what position/width it carries;
// every cycle the DUT outputs are compared with that prediction.
// -----------------------------------------------------------------------------
module tb_servo_pulse_decoder;

  localparam int MIN   = 200;
  localparam int STEP  = 2;
  localparam int SHORT = 100;
  localparam int LONG  = 800;
  localparam int TMO   = 3000;
  localparam int WW    = 17;

  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_SHORT = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b001;

  logic          clk = 1'b0;
  logic          key0;
  logic          pwm_in;
  logic [7:0]    position;
  logic [WW-1:0] pulse_width;
  logic          valid, err_short, err_long, signal_lost;

  servo_pulse_decoder #(
    .MIN_PULSE_CYC  (MIN),
    .STEP_CYC       (STEP),
    .SHORT_LIMIT_CYC(SHORT),
    .LONG_LIMIT_CYC (LONG),
    .TIMEOUT_CYC    (TMO),
    .WIDTH_W        (WW)
  ) dut (
    .CLOCK_50   (clk),
    .KEY0       (key0),
    .pwm_in     (pwm_in),
    .position   (position),
    .pulse_width(pulse_width),
    .valid      (valid),
    .err_short  (err_short),
    .err_long   (err_long),
    .signal_lost(signal_lost)
  );

  initial forever #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  typedef struct {
    int         at_edge;
    logic [2:0] kind;
    int         pw;
    int         pos;
  } ev_t;

  ev_t  evq[$];
  int   model_pos;
  int   model_pw;
  logic model_lost;
  bit   dl_en;
  int   dl_edge;
  int   last_valid_edge;
  int   n_cmp;
  int   n_fail;

  function automatic int exp_pos(input int w);
    int q;
    if (w < MIN) return 0;
    q = (w - MIN) / STEP;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, expv, edge_no);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_strobes"}, 32'({valid, err_short, err_long}), 32'(K_NONE));
    check({tag, "_position"}, 32'(position), 32'd0);
    check({tag, "_pulse_width"}, 32'(pulse_width), 32'd0);
    check({tag, "_signal_lost"}, 32'(signal_lost), 32'd1);
  endtask

  task automatic model_reset();
    evq.delete();
    model_pos  = 0;
    model_pw   = 0;
    model_lost = 1'b1;
    dl_en      = 1'b0;
  endtask

  // One clock: drive the pin away from the active edge, then compare all
  // outputs just after the edge against the model.
  task automatic step(input logic level);
    logic [2:0] expv;
    ev_t        ev;
    @(negedge clk);
    pwm_in = level;
    @(posedge clk);
    #1;
    expv = K_NONE;
    if (evq.size() > 0 && evq[0].at_edge == edge_no) begin
      ev   = evq.pop_front();
      expv = ev.kind;
      if (ev.kind == K_VALID) begin
        model_pos  = ev.pos;
        model_pw   = ev.pw;
        model_lost = 1'b0;
        dl_en      = 1'b0;
      end
    end
    if (dl_en && edge_no == dl_edge) model_lost = 1'b1;
    check("strobes", 32'({valid, err_short, err_long}), 32'(expv));
    check("position", 32'(position), 32'(model_pos));
    check("pulse_width", 32'(pulse_width), 32'(model_pw));
    check("signal_lost", 32'(signal_lost), 32'(model_lost));
  endtask

  // A pulse of n high samples followed by gap low samples. The outcome follows
  // from the decoding rules: the result appears three edges after the first low
  // sample, or, for an over-long pulse, three edges after the LONG-th high one.
  task automatic pulse(input int n, input int gap);
    ev_t ev;
    int  h;
    h      = edge_no + 1;
    ev.pw  = 0;
    ev.pos = 0;
    if (n >= LONG) begin
      ev.at_edge = h + LONG + 2;
      ev.kind    = K_LONG;
    end else if (n < SHORT) begin
      ev.at_edge = h + n + 3;
      ev.kind    = K_SHORT;
    end else begin
      ev.at_edge      = h + n + 3;
      ev.kind         = K_VALID;
      ev.pw           = n;
      ev.pos          = exp_pos(n);
      last_valid_edge = ev.at_edge;
    end
    evq.push_back(ev);
    repeat (n) step(1'b1);
    repeat (gap) step(1'b0);
  endtask

  initial begin
    int cat, n, gap;
    n_cmp  = 0;
    n_fail = 0;
    last_valid_edge = 0;
    dl_edge = 0;
    key0   = 1'b1;
    pwm_in = 1'b0;
    model_reset();

    // Reset state
    #2 key0 = 1'b0;
    #1 check_reset("reset");
    repeat (3) step(1'b0);
    @(negedge clk) key0 = 1'b1;
    repeat (100) step(1'b0);

    // First pulse: mid-range, clears signal_lost with the strobe
    pulse(454, 200);
    check("first_pw", 32'(pulse_width), 32'd454);
    check("first_pos", 32'(position), 32'd127);
    check("first_lost", 32'(signal_lost), 32'd0);

    // End points and saturation
    pulse(200, 300);
    check("min_pos", 32'(position), 32'd0);
    pulse(712, 300);
    check("sat_pos", 32'(position), 32'd255);
    check("sat_pw", 32'(pulse_width), 32'd712);
    pulse(710, 100);
    check("top_pos", 32'(position), 32'd255);
    pulse(709, 100);
    check("below_top_pos", 32'(position), 32'd254);
    pulse(202, 100);
    check("one_step_pos", 32'(position), 32'd1);
    pulse(201, 100);
    check("part_step_pos", 32'(position), 32'd0);

    // Short pulses are rejected and leave outputs alone
    pulse(454, 100);
    pulse(40, 100);
    check("short_hold_pos", 32'(position), 32'd127);
    pulse(99, 100);
    pulse(100, 100);
    check("short_limit_pos", 32'(position), 32'd0);
    check("short_limit_pw", 32'(pulse_width), 32'd100);
    pulse(454, 100);
    pulse(120, 100);
    check("sub_min_pos", 32'(position), 32'd0);

    // Long limit
    pulse(799, 100);
    check("long_m1_pos", 32'(position), 32'd255);
    pulse(1600, 100);
    check("long_hold_pw", 32'(pulse_width), 32'd799);
    pulse(454, 100);
    check("after_long_pos", 32'(position), 32'd127);

    // Timeout: a rising edge on the threshold cycle wins
    pulse(454, TMO);
    pulse(302, 5);
    check("rise_wins_lost", 32'(signal_lost), 32'd0);
    check("rise_wins_pos", 32'(position), 32'd51);
    dl_edge = last_valid_edge + TMO;
    dl_en   = 1'b1;
    repeat (TMO + 20) step(1'b0);
    check("timeout_lost", 32'(signal_lost), 32'd1);
    check("timeout_hold_pos", 32'(position), 32'd51);
    pulse(454, 50);
    check("recover_lost", 32'(signal_lost), 32'd0);

    // Reset mid-pulse, released while the line is still high
    repeat (300) step(1'b1);
    #2 key0 = 1'b0;
    #1;
    model_reset();
    check_reset("midpulse_reset");
    repeat (3) step(1'b1);
    @(negedge clk) key0 = 1'b1;
    repeat (400) step(1'b1);
    repeat (100) step(1'b0);
    pulse(302, 100);
    check("after_reset_pos", 32'(position), 32'd51);

    // Random pulse train; every fifth pulse is decodable so signal_lost stays 0
    for (int i = 0; i < 25; i++) begin
      cat = (i % 5 == 4) ? 2 : int'($urandom_range(3, 0));
      case (cat)
        0:       n = int'($urandom_range(SHORT - 1, 1));
        1:       n = int'($urandom_range(MIN - 1, SHORT));
        2:       n = int'($urandom_range(MIN + 255 * STEP + 30, MIN));
        default: n = int'($urandom_range(LONG + 100, LONG));
      endcase
      gap = int'($urandom_range(150, 1));
      pulse(n, gap);
    end
    pulse(454, 50);

    check("events_drained", 32'(evq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
